// File: rtl/alu_arbiter_2p.sv
// alu_arbiter_2p: two requesters share one 16-bit ALU behind a fair round-robin arbiter.
// Latency: accept at edge N, result registered at N+1, rsp_valid seen from N+1; one op per 3 cycles max.
// Backpressure: rsp_* held while rsp_valid && !rsp_ready; both req ready outputs stay 0 until the response leaves.
//
// Ports:
//   clk, rst                      - single clock, synchronous active-high reset
//   reqN_valid/ready/op/a/b       - requester N command port (N = 0, 1), valid/ready handshake
//   rsp_valid/ready               - response handshake
//   rsp_id, rsp_s                 - served requester, 16-bit result
//   rsp_ovf, rsp_zero, rsp_err    - ALU overflow, ALU zero, illegal opcode flag
//
// Build option: define ALU_ARB_OPCHECK_EN to trap illegal opcodes (7, 11, 13, 15) and report
// them through rsp_err with a forced zero result; without it they reach the ALU and rsp_err is 0.

// alu16bit: 16-bit combinational ALU.
// Latency: 0 (pure combinational).
// Backpressure: none.
module alu16bit (
  input  logic [3:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] s,
  output logic        ovf,
  output logic        zero
);

  localparam logic [3:0] OP_SUB = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_OR  = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_DEC = 4'd4;
  localparam logic [3:0] OP_INC = 4'd5;
  localparam logic [3:0] OP_INV = 4'd6;
  localparam logic [3:0] OP_LSL = 4'd8;
  localparam logic [3:0] OP_LEQ = 4'd9;
  localparam logic [3:0] OP_LSR = 4'd10;
  localparam logic [3:0] OP_ASL = 4'd12;
  localparam logic [3:0] OP_ASR = 4'd14;

  logic [3:0]  sh;
  logic [31:0] asl_w;

  // Shifts use b[3:0] as the shift distance.
  assign sh = b[3:0];
  // Sign-extended shift: ASL overflows when the bits pushed past bit 15 disagree with the new sign.
  assign asl_w = {{16{a[15]}}, a} << sh;

  always_comb begin
    s   = 16'h0000;
    ovf = 1'b0;
    case (op)
      OP_SUB: begin
        s   = a - b;
        ovf = (a[15] != b[15]) && (s[15] != a[15]);
      end
      OP_ADD: begin
        s   = a + b;
        ovf = (a[15] == b[15]) && (s[15] != a[15]);
      end
      OP_OR:  s = a | b;
      OP_AND: s = a & b;
      OP_DEC: begin
        s   = a - 16'd1;
        ovf = (a == 16'h8000);
      end
      OP_INC: begin
        s   = a + 16'd1;
        ovf = (a == 16'h7FFF);
      end
      OP_INV: s = ~a;
      OP_LSL: s = a << sh;
      OP_LEQ: s = {15'd0, (a <= b)};
      OP_LSR: s = a >> sh;
      OP_ASL: begin
        s   = asl_w[15:0];
        ovf = (asl_w[31:15] != {17{asl_w[15]}});
      end
      OP_ASR: s = $unsigned($signed(a) >>> sh);
      default: begin
        s   = 16'h0000;
        ovf = 1'b0;
      end
    endcase
  end

  assign zero = (s == 16'h0000);

endmodule

module alu_arbiter_2p (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_s,
  output logic        rsp_ovf,
  output logic        rsp_zero,
  output logic        rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
  } cmd_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  cmd_t        cmd_q, cmd_d;
  logic        id_q, id_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic [15:0] rsp_s_q, rsp_s_d;
  logic        rsp_ovf_q, rsp_ovf_d;
  logic        rsp_zero_q, rsp_zero_d;

  logic        grant0, grant1;
  logic        accept;
  logic [15:0] alu_s;
  logic        alu_ovf, alu_zero;

  // The shared ALU sees only the registered command, never the live request ports.
  alu16bit u_alu (
    .op   (cmd_q.op),
    .a    (cmd_q.a),
    .b    (cmd_q.b),
    .s    (alu_s),
    .ovf  (alu_ovf),
    .zero (alu_zero)
  );

  // On a tie the port that did not win last time is granted.
  assign grant0 = req0_valid && (!req1_valid || last_grant_q);
  assign grant1 = req1_valid && (!req0_valid || !last_grant_q);

  // rst gates ready so nothing is accepted on a reset edge.
  assign req0_ready = !rst && (state_q == IDLE) && grant0;
  assign req1_ready = !rst && (state_q == IDLE) && grant1;
  assign accept     = req0_ready || req1_ready;

`ifdef ALU_ARB_OPCHECK_EN
  logic rsp_err_q, rsp_err_d;
  logic op_illegal;

  assign op_illegal = (cmd_q.op == 4'd7) || (cmd_q.op == 4'd11) ||
                      (cmd_q.op == 4'd13) || (cmd_q.op == 4'd15);
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cmd_d        = cmd_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_s_d      = rsp_s_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_zero_d   = rsp_zero_q;
`ifdef ALU_ARB_OPCHECK_EN
    rsp_err_d    = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          cmd_d        = req1_ready ? '{op: req1_op, a: req1_a, b: req1_b}
                                    : '{op: req0_op, a: req0_a, b: req0_b};
          id_d         = req1_ready;
          last_grant_d = req1_ready;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_s_d     = alu_s;
        rsp_ovf_d   = alu_ovf;
        rsp_zero_d  = alu_zero;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
`ifdef ALU_ARB_OPCHECK_EN
        rsp_err_d   = op_illegal;
        if (op_illegal) begin
          rsp_s_d    = 16'h0000;
          rsp_ovf_d  = 1'b0;
          rsp_zero_d = 1'b1;
        end
`endif
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cmd_q        <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_s_q      <= 16'h0000;
      rsp_ovf_q    <= 1'b0;
      rsp_zero_q   <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cmd_q        <= cmd_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_s_q      <= rsp_s_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_zero_q   <= rsp_zero_d;
`ifdef ALU_ARB_OPCHECK_EN
      rsp_err_q    <= rsp_err_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_s     = rsp_s_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_zero  = rsp_zero_q;
`ifdef ALU_ARB_OPCHECK_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter_2p.sv
// tb_alu_arbiter_2p: directed scenarios plus randomized traffic against a transaction-level model.
// Latency: n/a (testbench).
// Backpressure: randomly toggles rsp_ready to stall responses.
module tb_alu_arbiter_2p;

`ifdef ALU_ARB_OPCHECK_EN
  localparam bit OPCHK = 1'b1;
`else
  localparam bit OPCHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [3:0]  req0_op;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_ready;
  logic [3:0]  req1_op;
  logic [15:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [15:0] rsp_s;
  logic        rsp_ovf, rsp_zero, rsp_err;

  always #5 clk = ~clk;

  alu_arbiter_2p dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_s      (rsp_s),
    .rsp_ovf    (rsp_ovf),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic        id;
    logic [15:0] s;
    logic        ovf;
    logic        zero;
    logic        err;
  } rsp_t;

  // Reference ALU: signed results as plain integers, overflow = result outside 16-bit signed range.
  function automatic rsp_t ref_rsp(input logic id, input logic [3:0] op,
                                   input logic [15:0] a, input logic [15:0] b);
    rsp_t r;
    int   sa, sb, sh, v;
    logic [15:0] t;
    sa = int'($signed(a));
    sb = int'($signed(b));
    sh = int'(b[3:0]);
    v  = 0;
    t  = 16'h0000;
    r.id  = id;
    r.ovf = 1'b0;
    r.err = 1'b0;
    case (op)
      4'd0:  begin v = sa - sb; t = v[15:0]; r.ovf = (v > 32767) || (v < -32768); end
      4'd1:  begin v = sa + sb; t = v[15:0]; r.ovf = (v > 32767) || (v < -32768); end
      4'd2:  t = a | b;
      4'd3:  t = a & b;
      4'd4:  begin v = sa - 1; t = v[15:0]; r.ovf = (v < -32768); end
      4'd5:  begin v = sa + 1; t = v[15:0]; r.ovf = (v > 32767); end
      4'd6:  t = ~a;
      4'd8:  begin v = int'(a) * (1 << sh); t = v[15:0]; end
      4'd9:  t = (int'(a) <= int'(b)) ? 16'd1 : 16'd0;
      4'd10: begin v = int'(a) / (1 << sh); t = v[15:0]; end
      4'd12: begin v = sa * (1 << sh); t = v[15:0]; r.ovf = (v > 32767) || (v < -32768); end
      4'd14: begin v = sa >>> sh; t = v[15:0]; end
      default: begin t = 16'h0000; r.err = OPCHK; end
    endcase
    r.s    = t;
    r.zero = (t == 16'h0000);
    return r;
  endfunction

  // Transaction model: at most one op outstanding; its response is due 2 cycles after accept.
  rsp_t exp_q[$];
  int   age = 0;
  logic last_g = 1'b1;
  bit   mon_en = 1'b0;
  logic m_g0, m_g1, m_idle;

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() != 0) age++;
      m_g0   = req0_valid && (!req1_valid || last_g);
      m_g1   = req1_valid && (!req0_valid || !last_g);
      m_idle = (exp_q.size() == 0) && !rst;
      check("mon_rdy0", req0_ready, m_idle && m_g0);
      check("mon_rdy1", req1_ready, m_idle && m_g1);
      check("mon_vld", rsp_valid, (exp_q.size() != 0) && (age >= 2));
      if (rsp_valid && exp_q.size() != 0) begin
        check("mon_id",   rsp_id,   exp_q[0].id);
        check("mon_s",    rsp_s,    exp_q[0].s);
        check("mon_ovf",  rsp_ovf,  exp_q[0].ovf);
        check("mon_zero", rsp_zero, exp_q[0].zero);
        check("mon_err",  rsp_err,  exp_q[0].err);
        if (rsp_ready) void'(exp_q.pop_front());
      end
      if (!rst && req0_valid && req0_ready) begin
        exp_q.push_back(ref_rsp(1'b0, req0_op, req0_a, req0_b));
        age    = 0;
        last_g = 1'b0;
      end else if (!rst && req1_valid && req1_ready) begin
        exp_q.push_back(ref_rsp(1'b1, req1_op, req1_a, req1_b));
        age    = 0;
        last_g = 1'b1;
      end
      if (rst) begin
        exp_q.delete();
        age    = 0;
        last_g = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [15:0] rand16();
    case ($urandom_range(0, 3))
      0: return 16'h7FFF;
      1: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int          n;
    logic [3:0]  ids;
    rst = 1'b1;
    req0_valid = 1'b1; req0_op = 4'd1; req0_a = 16'h0; req0_b = 16'h0;
    req1_valid = 1'b0; req1_op = 4'd1; req1_a = 16'h0; req1_b = 16'h0;
    rsp_ready = 1'b1;
    ids = 4'h0;
    tick();
    mon_en = 1'b1;
    tick();
    // Reset state, with a valid request present during reset.
    check("rst_rdy0", req0_ready, 1'b0);
    check("rst_vld",  rsp_valid,  1'b0);
    check("rst_id",   rsp_id,     1'b0);
    check("rst_s",    rsp_s,      16'h0000);
    check("rst_ovf",  rsp_ovf,    1'b0);
    check("rst_zero", rsp_zero,   1'b0);
    check("rst_err",  rsp_err,    1'b0);
    req0_valid = 1'b0;
    rst = 1'b0;
    tick();

    // Single request: ADD 3 + 4.
    req0_valid = 1'b1; req0_op = 4'd1; req0_a = 16'h0003; req0_b = 16'h0004;
    #1;
    check("single_rdy0", req0_ready, 1'b1);
    tick();
    req0_valid = 1'b0;
    check("single_lat1", rsp_valid, 1'b0);
    tick();
    check("single_vld",  rsp_valid, 1'b1);
    check("single_s",    rsp_s,     16'h0007);
    check("single_id",   rsp_id,    1'b0);
    check("single_zero", rsp_zero,  1'b0);
    tick();
    check("single_done", rsp_valid, 1'b0);

    // Tie right after reset: port 0 first.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0_valid = 1'b1; req0_op = 4'd0; req0_a = 16'h0005; req0_b = 16'h0005;
    req1_valid = 1'b1; req1_op = 4'd2; req1_a = 16'h00F0; req1_b = 16'h000F;
    tick();
    req0_valid = 1'b0;
    tick();
    check("tie_vld0",  rsp_valid, 1'b1);
    check("tie_id0",   rsp_id,    1'b0);
    check("tie_s0",    rsp_s,     16'h0000);
    check("tie_zero0", rsp_zero,  1'b1);
    tick();
    #1;
    check("tie_rdy1", req1_ready, 1'b1);
    tick();
    req1_valid = 1'b0;
    tick();
    check("tie_id1", rsp_id, 1'b1);
    check("tie_s1",  rsp_s,  16'h00FF);
    tick();

    // Fairness and throughput: both held valid for 12 cycles -> 4 ops alternating.
    req0_valid = 1'b1; req0_op = 4'd5; req0_a = 16'h0100;
    req1_valid = 1'b1; req1_op = 4'd4; req1_a = 16'h0200;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (rsp_valid) begin
        if (n < 4) ids[n] = rsp_id;
        n++;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("fair_cnt", n, 4);
    check("fair_ids", ids, 4'b1010);
    tick();

    // Backpressure: ADD 0x7FFF + 1 stalled 5 cycles while port 1 waits.
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 4'd1; req0_a = 16'h7FFF; req0_b = 16'h0001;
    req1_valid = 1'b1; req1_op = 4'd3; req1_a = 16'hFFFF; req1_b = 16'h00FF;
    tick();
    req0_valid = 1'b0;
    check("bp_rdy1_exec", req1_ready, 1'b0);
    tick();
    for (int c = 0; c < 5; c++) begin
      check("bp_vld",  rsp_valid,  1'b1);
      check("bp_s",    rsp_s,      16'h8000);
      check("bp_ovf",  rsp_ovf,    1'b1);
      check("bp_rdy1", req1_ready, 1'b0);
      tick();
    end
    rsp_ready = 1'b1;
    check("bp_hold", rsp_s, 16'h8000);
    tick();
    check("bp_done", rsp_valid,  1'b0);
    check("bp_idle", req1_ready, 1'b1);
    tick();
    req1_valid = 1'b0;
    tick();
    check("bp_s1", rsp_s, 16'h00FF);
    tick();

    // Reset while in EXEC: operation dropped, next tie goes to port 0.
    req0_valid = 1'b1; req0_op = 4'd5; req0_a = 16'h0010; req0_b = 16'h0000;
    tick();
    req0_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_vld",  rsp_valid, 1'b0);
    check("mid_s",    rsp_s,     16'h0000);
    check("mid_id",   rsp_id,    1'b0);
    check("mid_ovf",  rsp_ovf,   1'b0);
    check("mid_zero", rsp_zero,  1'b0);
    check("mid_err",  rsp_err,   1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("mid_noresp", rsp_valid, 1'b0);
    end
    req0_valid = 1'b1; req0_op = 4'd2; req0_a = 16'h1200; req0_b = 16'h0034;
    req1_valid = 1'b1; req1_op = 4'd3;
    #1;
    check("mid_tie0", req0_ready, 1'b1);
    check("mid_tie1", req1_ready, 1'b0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    check("mid_s2", rsp_s, 16'h1234);
    tick();

    // Illegal opcode 7.
    req0_valid = 1'b1; req0_op = 4'd7; req0_a = 16'h1234; req0_b = 16'h0001;
    tick();
    req0_valid = 1'b0;
    tick();
    check("ill_vld",  rsp_valid, 1'b1);
    check("ill_err",  rsp_err,   OPCHK);
    check("ill_s",    rsp_s,     16'h0000);
    check("ill_zero", rsp_zero,  1'b1);
    tick();

    // Randomized traffic with stalls and occasional resets; the monitor checks every cycle.
    for (int c = 0; c < 1500; c++) begin
      rst        = ($urandom_range(0, 199) == 0);
      rsp_ready  = ($urandom_range(0, 3) != 0);
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_op = 4'($urandom_range(0, 15)); req0_a = rand16(); req0_b = rand16();
      req1_op = 4'($urandom_range(0, 15)); req1_a = rand16(); req1_b = rand16();
      tick();
    end

    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
    tick();
    check("drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
